// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game controller.
package pong_pkg;

    localparam int POS_W   = 8;
    localparam int VEL_W   = 4;
    localparam int SCORE_W = 4;

    localparam logic signed [VEL_W-1:0] SERVE_VX = 4'sd2;
    localparam logic signed [VEL_W-1:0] SERVE_VY = 4'sd1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        SCORED    = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Bus between the game controller and the combinational pong step datapath.
interface pong_game_ctrl_if;
    import pong_pkg::*;

    logic signed [POS_W-1:0]   cur_paddle_1_pos;
    logic signed [POS_W-1:0]   cur_paddle_2_pos;
    logic signed [POS_W-1:0]   cur_ball_pos_x;
    logic signed [POS_W-1:0]   cur_ball_pos_y;
    logic signed [VEL_W-1:0]   cur_ball_vel_x;
    logic signed [VEL_W-1:0]   cur_ball_vel_y;
    logic        [SCORE_W-1:0] cur_score_p1;
    logic        [SCORE_W-1:0] cur_score_p2;
    logic signed [1:0]         dp_control_1;
    logic signed [1:0]         dp_control_2;

    logic signed [POS_W-1:0]   nxt_paddle_1_pos;
    logic signed [POS_W-1:0]   nxt_paddle_2_pos;
    logic signed [POS_W-1:0]   nxt_ball_pos_x;
    logic signed [POS_W-1:0]   nxt_ball_pos_y;
    logic signed [VEL_W-1:0]   nxt_ball_vel_x;
    logic signed [VEL_W-1:0]   nxt_ball_vel_y;
    logic        [SCORE_W-1:0] nxt_score_p1;
    logic        [SCORE_W-1:0] nxt_score_p2;
    logic                      nxt_bounce;

    modport master (
        output cur_paddle_1_pos, cur_paddle_2_pos, cur_ball_pos_x, cur_ball_pos_y,
               cur_ball_vel_x, cur_ball_vel_y, cur_score_p1, cur_score_p2,
               dp_control_1, dp_control_2,
        input  nxt_paddle_1_pos, nxt_paddle_2_pos, nxt_ball_pos_x, nxt_ball_pos_y,
               nxt_ball_vel_x, nxt_ball_vel_y, nxt_score_p1, nxt_score_p2, nxt_bounce
    );

    modport slave (
        input  cur_paddle_1_pos, cur_paddle_2_pos, cur_ball_pos_x, cur_ball_pos_y,
               cur_ball_vel_x, cur_ball_vel_y, cur_score_p1, cur_score_p2,
               dp_control_1, dp_control_2,
        output nxt_paddle_1_pos, nxt_paddle_2_pos, nxt_ball_pos_x, nxt_ball_pos_y,
               nxt_ball_vel_x, nxt_ball_vel_y, nxt_score_p1, nxt_score_p2, nxt_bounce
    );

endinterface

// File: rtl/pong_game_ctrl_frame_divider.sv
// Free-running frame divider: one-cycle tick every FRAME_DIV clocks.
module frame_divider #(
    parameter int FRAME_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic frame_tick
);

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0] count;

    // Count 0..FRAME_DIV-1 and wrap, independent of game state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign frame_tick = (count == LAST);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: owns game-state registers, commits datapath results
// once per unpaused frame and runs the serve/play/score/game-over FSM.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int FRAME_DIV    = 1000,
    parameter int SERVE_FRAMES = 30,
    parameter int WIN_SCORE    = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic signed [1:0] in_control_1,
    input  logic signed [1:0] in_control_2,
    pong_game_ctrl_if.master  dp,
    output logic              frame_tick,
    output logic [2:0]        state,
    output logic [1:0]        winner,
    output logic [7:0]        rally
);

    localparam int SCNT_W = $clog2(SERVE_FRAMES + 1);
    localparam logic [SCNT_W-1:0]  SERVE_LAST = SCNT_W'(SERVE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);

    state_t              state_q, state_d;
    logic                serve_neg, serve_neg_d;   // 1: next serve goes towards -x
    logic [SCNT_W-1:0]   serve_cnt;
    logic                p1_scored;
    winner_t             winner_q;
    logic                commit;
    logic                enter_serve;
    logic                new_game;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    frame_divider #(.FRAME_DIV(FRAME_DIV)) u_div (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick)
    );

    assign commit      = frame_tick & ~pause;
    assign new_game    = ((state_q == IDLE) || (state_q == GAME_OVER)) && start;
    assign enter_serve = (state_d == SERVE) && (state_q != SERVE);

    // Next-state and serve-direction decision.
    always_comb begin
        state_d     = state_q;
        serve_neg_d = serve_neg;
        case (state_q)
            IDLE, GAME_OVER: begin
                if (start) begin
                    state_d     = SERVE;
                    serve_neg_d = 1'b0;
                end
            end
            SERVE: begin
                if (commit && (serve_cnt == SERVE_LAST)) state_d = PLAY;
            end
            PLAY: begin
                if (commit && ((dp.nxt_score_p1 != dp.cur_score_p1) ||
                               (dp.nxt_score_p2 != dp.cur_score_p2))) state_d = SCORED;
            end
            SCORED: begin
                if (p1_scored) begin
                    serve_neg_d = 1'b0;
                    state_d     = (dp.cur_score_p1 >= WIN_S) ? GAME_OVER : SERVE;
                end else begin
                    serve_neg_d = 1'b1;
                    state_d     = (dp.cur_score_p2 >= WIN_S) ? GAME_OVER : SERVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers: FSM state, serve bookkeeping, rally and winner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            serve_neg <= 1'b0;
            serve_cnt <= '0;
            p1_scored <= 1'b0;
            rally     <= 8'd0;
            winner_q  <= WIN_NONE;
        end else begin
            state_q   <= state_d;
            serve_neg <= serve_neg_d;
            if (new_game) winner_q <= WIN_NONE;
            if (enter_serve) begin
                serve_cnt <= '0;
                rally     <= 8'd0;
            end else if (state_q == SERVE && commit) begin
                serve_cnt <= serve_cnt + SCNT_W'(1);
            end else if (state_q == PLAY && commit) begin
                p1_scored <= (dp.nxt_score_p1 != dp.cur_score_p1);
                if (dp.nxt_bounce) rally <= sat_inc(rally);
            end
            if (state_q == SCORED && state_d == GAME_OVER)
                winner_q <= p1_scored ? WIN_P1 : WIN_P2;
        end
    end

    // Game-state registers presented to the datapath and display.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp.cur_paddle_1_pos <= '0;
            dp.cur_paddle_2_pos <= '0;
            dp.cur_ball_pos_x   <= '0;
            dp.cur_ball_pos_y   <= '0;
            dp.cur_ball_vel_x   <= '0;
            dp.cur_ball_vel_y   <= '0;
            dp.cur_score_p1     <= '0;
            dp.cur_score_p2     <= '0;
        end else begin
            if (new_game) begin
                dp.cur_score_p1 <= '0;
                dp.cur_score_p2 <= '0;
            end
            if (enter_serve) begin
                dp.cur_ball_pos_x <= '0;
                dp.cur_ball_pos_y <= '0;
                dp.cur_ball_vel_x <= serve_neg_d ? -SERVE_VX : SERVE_VX;
                dp.cur_ball_vel_y <= SERVE_VY;
            end else if (state_q == SERVE && commit) begin
                dp.cur_paddle_1_pos <= dp.nxt_paddle_1_pos;
                dp.cur_paddle_2_pos <= dp.nxt_paddle_2_pos;
            end else if (state_q == PLAY && commit) begin
                dp.cur_paddle_1_pos <= dp.nxt_paddle_1_pos;
                dp.cur_paddle_2_pos <= dp.nxt_paddle_2_pos;
                dp.cur_ball_pos_x   <= dp.nxt_ball_pos_x;
                dp.cur_ball_pos_y   <= dp.nxt_ball_pos_y;
                dp.cur_ball_vel_x   <= dp.nxt_ball_vel_x;
                dp.cur_ball_vel_y   <= dp.nxt_ball_vel_y;
                dp.cur_score_p1     <= dp.nxt_score_p1;
                dp.cur_score_p2     <= dp.nxt_score_p2;
            end
        end
    end

    assign dp.dp_control_1 = (state_q == SERVE || state_q == PLAY) ? in_control_1 : 2'sd0;
    assign dp.dp_control_2 = (state_q == SERVE || state_q == PLAY) ? in_control_2 : 2'sd0;
    assign state  = state_q;
    assign winner = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed testbench for pong_game_ctrl (FRAME_DIV=4, SERVE_FRAMES=3, WIN_SCORE=2).
module tb_pong_game_ctrl;
    import pong_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              pause;
    logic signed [1:0] in_control_1;
    logic signed [1:0] in_control_2;
    logic              frame_tick;
    logic [2:0]        state;
    logic [1:0]        winner;
    logic [7:0]        rally;

    int n_checks = 0;
    int n_fail   = 0;

    pong_game_ctrl_if dp();

    pong_game_ctrl #(.FRAME_DIV(4), .SERVE_FRAMES(3), .WIN_SCORE(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pause        (pause),
        .in_control_1 (in_control_1),
        .in_control_2 (in_control_2),
        .dp           (dp),
        .frame_tick   (frame_tick),
        .state        (state),
        .winner       (winner),
        .rally        (rally)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // Waits (at negedges) until state matches target; cycles counts edges taken.
    task automatic wait_state(input logic [2:0] target, input int budget,
                              output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cycles++;
            if (state === target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Returns at a negedge within a frame_tick cycle (current one included).
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (frame_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; pause = 1'b0;
        in_control_1 = 2'sd1; in_control_2 = -2'sd1;
        dp.nxt_paddle_1_pos = '0; dp.nxt_paddle_2_pos = '0;
        dp.nxt_ball_pos_x = '0;   dp.nxt_ball_pos_y = '0;
        dp.nxt_ball_vel_x = '0;   dp.nxt_ball_vel_y = '0;
        dp.nxt_score_p1 = '0;     dp.nxt_score_p2 = '0;
        dp.nxt_bounce = 1'b0;
        #12;
        n_checks++;
        if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d, expected 0", state); end
        n_checks++;
        if (frame_tick !== 1'b0 || winner !== 2'b00 || rally !== 8'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got tick=%0b winner=%0b rally=%0d, expected 0/00/0", frame_tick, winner, rally);
        end
        n_checks++;
        if (dp.cur_ball_vel_x !== 4'sd0 || dp.cur_paddle_1_pos !== 8'sd0 || dp.cur_score_p1 !== 4'd0) begin
            n_fail++; $display("FAIL reset_regs: got velx=%0d pad1=%0d s1=%0d, expected 0", dp.cur_ball_vel_x, dp.cur_paddle_1_pos, dp.cur_score_p1);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (state !== 3'd0 || dp.dp_control_1 !== 2'sd0) begin
            n_fail++; $display("FAIL idle_hold: got state=%0d ctl1=%0d, expected 0/0", state, dp.dp_control_1);
        end
    endtask

    task automatic test_divider();
        bit ok;
        int n;
        for (int k = 0; k < 2; k++) begin
            wait_tick(ok);
            n = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                n++;
                if (frame_tick === 1'b1) break;
            end
            n_checks++;
            if (!ok || n !== 4) begin n_fail++; $display("FAIL tick_period: got %0d, expected 4", n); end
        end
    endtask

    task automatic test_serve_to_play();
        bit ok;
        int n;
        dp.nxt_paddle_1_pos = 8'sd10;
        dp.nxt_ball_pos_x   = 8'sd9;
        wait_tick(ok);
        start = 1'b1;
        wait_state(3'd1, 4, n, ok);
        start = 1'b0;
        n_checks++;
        if (!ok || n !== 1) begin n_fail++; $display("FAIL start_latency: got %0d, expected 1", n); end
        n_checks++;
        if (dp.cur_ball_vel_x !== 4'sd2 || dp.cur_ball_vel_y !== 4'sd1) begin
            n_fail++; $display("FAIL serve_vel: got (%0d,%0d), expected (2,1)", dp.cur_ball_vel_x, dp.cur_ball_vel_y);
        end
        n_checks++;
        if (dp.dp_control_1 !== 2'sd1 || dp.dp_control_2 !== -2'sd1) begin
            n_fail++; $display("FAIL serve_ctl: got (%0d,%0d), expected (1,-1)", dp.dp_control_1, dp.dp_control_2);
        end
        wait_state(3'd2, 40, n, ok);
        n_checks++;
        if (!ok || n !== 12) begin n_fail++; $display("FAIL serve_to_play: got %0d cycles, expected 12", n); end
        n_checks++;
        if (dp.cur_paddle_1_pos !== 8'sd10 || dp.cur_ball_pos_x !== 8'sd0) begin
            n_fail++; $display("FAIL serve_regs: got pad1=%0d bx=%0d, expected 10/0", dp.cur_paddle_1_pos, dp.cur_ball_pos_x);
        end
    endtask

    task automatic test_pause();
        bit ok;
        pause = 1'b1;
        dp.nxt_ball_pos_x = 8'sd5;
        for (int k = 0; k < 3; k++) begin
            wait_tick(ok);
            @(negedge clk);
            n_checks++;
            if (!ok || dp.cur_ball_pos_x !== 8'sd0) begin
                n_fail++; $display("FAIL pause_hold: got %0d, expected 0", dp.cur_ball_pos_x);
            end
        end
        pause = 1'b0;
        dp.nxt_bounce = 1'b1;
        wait_tick(ok);
        @(negedge clk);
        dp.nxt_bounce = 1'b0;
        n_checks++;
        if (!ok || dp.cur_ball_pos_x !== 8'sd5 || rally !== 8'd1) begin
            n_fail++; $display("FAIL pause_release: got bx=%0d rally=%0d, expected 5/1", dp.cur_ball_pos_x, rally);
        end
    endtask

    task automatic test_score_p2();
        bit ok;
        dp.nxt_score_p2 = 4'd1;
        wait_tick(ok);
        @(negedge clk);
        n_checks++;
        if (!ok || state !== 3'd3 || dp.cur_score_p2 !== 4'd1) begin
            n_fail++; $display("FAIL p2_scored: got state=%0d s2=%0d, expected 3/1", state, dp.cur_score_p2);
        end
        @(negedge clk);
        n_checks++;
        if (state !== 3'd1 || dp.cur_ball_vel_x !== -4'sd2 || rally !== 8'd0 || dp.cur_ball_pos_x !== 8'sd0) begin
            n_fail++; $display("FAIL p2_reserve: got state=%0d vx=%0d rally=%0d bx=%0d, expected 1/-2/0/0", state, dp.cur_ball_vel_x, rally, dp.cur_ball_pos_x);
        end
    endtask

    task automatic test_game_over();
        bit ok;
        int n;
        wait_state(3'd2, 100, n, ok);
        dp.nxt_score_p1 = 4'd1;
        wait_tick(ok);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (state !== 3'd1 || dp.cur_ball_vel_x !== 4'sd2 || dp.cur_score_p1 !== 4'd1) begin
            n_fail++; $display("FAIL p1_reserve: got state=%0d vx=%0d s1=%0d, expected 1/2/1", state, dp.cur_ball_vel_x, dp.cur_score_p1);
        end
        wait_state(3'd2, 100, n, ok);
        dp.nxt_score_p1 = 4'd2;
        wait_tick(ok);
        @(negedge clk);
        n_checks++;
        if (state !== 3'd3 || winner !== 2'b00) begin
            n_fail++; $display("FAIL win_scored: got state=%0d winner=%0b, expected 3/00", state, winner);
        end
        @(negedge clk);
        n_checks++;
        if (state !== 3'd4 || winner !== 2'b01 || dp.cur_score_p1 !== 4'd2) begin
            n_fail++; $display("FAIL game_over: got state=%0d winner=%0b s1=%0d, expected 4/01/2", state, winner, dp.cur_score_p1);
        end
        dp.nxt_paddle_1_pos = 8'sd33;
        repeat (9) @(negedge clk);
        n_checks++;
        if (state !== 3'd4 || winner !== 2'b01 || dp.cur_paddle_1_pos !== 8'sd10 || dp.dp_control_1 !== 2'sd0) begin
            n_fail++; $display("FAIL over_hold: got state=%0d winner=%0b pad1=%0d ctl1=%0d, expected 4/01/10/0", state, winner, dp.cur_paddle_1_pos, dp.dp_control_1);
        end
        dp.nxt_score_p1 = 4'd0;
        dp.nxt_score_p2 = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (state !== 3'd1 || dp.cur_score_p1 !== 4'd0 || dp.cur_score_p2 !== 4'd0 || winner !== 2'b00 || dp.cur_ball_vel_x !== 4'sd2) begin
            n_fail++; $display("FAIL restart: got state=%0d s1=%0d s2=%0d winner=%0b vx=%0d, expected 1/0/0/00/2", state, dp.cur_score_p1, dp.cur_score_p2, winner, dp.cur_ball_vel_x);
        end
    endtask

    task automatic test_reset_mid_play();
        bit ok;
        int n;
        wait_state(3'd2, 100, n, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL reach_play: got state=%0d, expected 2", state); end
        dp.nxt_paddle_2_pos = -8'sd7;
        dp.nxt_ball_pos_y   = -8'sd3;
        dp.nxt_bounce       = 1'b1;
        wait_tick(ok);
        @(negedge clk);
        dp.nxt_bounce = 1'b0;
        n_checks++;
        if (dp.cur_paddle_2_pos !== -8'sd7 || dp.cur_ball_pos_y !== -8'sd3 || rally !== 8'd1) begin
            n_fail++; $display("FAIL play_load: got pad2=%0d by=%0d rally=%0d, expected -7/-3/1", dp.cur_paddle_2_pos, dp.cur_ball_pos_y, rally);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (state !== 3'd0 || dp.cur_paddle_2_pos !== 8'sd0 || dp.cur_ball_pos_y !== 8'sd0 ||
            dp.cur_ball_vel_x !== 4'sd0 || rally !== 8'd0 || frame_tick !== 1'b0 || dp.dp_control_1 !== 2'sd0) begin
            n_fail++; $display("FAIL async_reset: got state=%0d pad2=%0d by=%0d vx=%0d rally=%0d tick=%0b, expected all 0", state, dp.cur_paddle_2_pos, dp.cur_ball_pos_y, dp.cur_ball_vel_x, rally, frame_tick);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (state !== 3'd0) begin n_fail++; $display("FAIL post_reset: got %0d, expected 0", state); end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_serve_to_play();
        test_pause();
        test_score_p2();
        test_game_over();
        test_reset_mid_play();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
